rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
Parametrised rectangle rasteriser for the VGA adapter path. It generalises the fixed 4x4 square drawer to any W x H up to MAX_W x MAX_H, with latched origin and colour, a fill/outline mode, and a go/busy/done handshake. It emits one pixel (x, y, colour, plot) per clock, straight into the VGA adapter write port.

Parameters:
MAX_W, 16, largest rectangle width in pixels (>=1)
MAX_H, 16, largest rectangle height in pixels (>=1)
X_BITS, 8, x coordinate width
Y_BITS, 7, y coordinate width
COLOUR_BITS, 3, colour width
SCREEN_W, 160, visible width (used only with clipping)
SCREEN_H, 120, visible height (used only with clipping)

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
go  in  1  start request, sampled only in IDLE
x_in  in  X_BITS  origin x (top-left)
y_in  in  Y_BITS  origin y (top-left)
w_in  in  $clog2(MAX_W+1)  width in pixels
h_in  in  $clog2(MAX_H+1)  height in pixels
colour_in  in  COLOUR_BITS  draw colour
outline  in  1  0 = filled, 1 = border only
busy  out  1  engine is not accepting go
done  out  1  one-cycle pulse when the rectangle completes
x_out  out  X_BITS  pixel x to VGA
y_out  out  Y_BITS  pixel y to VGA
colour_out  out  COLOUR_BITS  pixel colour to VGA
plot  out  1  write enable to VGA

Behaviour:
- Reset (async, resetn=0): state IDLE. busy, done, plot, x_out, y_out and colour_out are all 0. Counters clear. Reset mid-draw aborts immediately, with no done pulse.
- States: IDLE, DRAW, FINISH. All outputs are registered.
- IDLE: busy=0, plot=0, done=0.
  - At an edge with go=1, the engine latches x_in, y_in, colour_in and outline.
  - It also latches w_in and h_in, clamped to MAX_W and MAX_H.
  - If the clamped width or height is 0, it goes to FINISH and plots nothing.
  - Otherwise it goes to DRAW, with pixel (0,0) presented in the cycle after the sampling edge.
- DRAW: busy=1. One pixel per cycle in raster order, x offset inner (0..W-1), y offset outer (0..H-1).
  - x_out = x0 + xo and y_out = y0 + yo, each truncated to X_BITS or Y_BITS, so coordinates wrap modulo 2^bits.
  - colour_out = latched colour.
  - plot=1 for every pixel in fill mode.
  - In outline mode, plot=1 only when xo==0, xo==W-1, yo==0 or yo==H-1. Interior pixels still take one cycle each, with plot=0.
  - After pixel (W-1,H-1) the engine goes to FINISH. DRAW always lasts exactly W*H cycles.
- FINISH: one cycle; done=1, busy=1, plot=0. It then returns to IDLE, so busy=0 in the following cycle.
- Latency: the go edge is followed by W*H pixel cycles, then 1 done cycle. go may be held high; a new rectangle starts at the first IDLE edge.
- go while busy=1 is ignored. Input changes during DRAW have no effect, because all inputs are latched.

Optional Feature:
RECT_CLIP_EN.
- Defined: pixel coordinates are computed at X_BITS+1 / Y_BITS+1 width. plot is forced to 0 when the unwrapped x >= SCREEN_W or y >= SCREEN_H. Timing and done are unchanged.
- Undefined: no clipping. Coordinates wrap modulo 2^X_BITS / 2^Y_BITS as described under DRAW.

Test Plan:
- Fill 4x4 at (10,20), colour 5, go pulsed at edge E0 -> 16 plots, in order (10,20),(11,20)..(13,23), all with colour_out=5. done=1 for exactly one cycle after E16. busy=0 after E17.
- Outline 4x3 at (0,0) -> DRAW lasts 12 cycles. Exactly 10 plots; (1,1) and (2,1) have plot=0. done follows.
- w_in=0, h_in=5 -> no plot; done pulses in the cycle after the go edge. w_in=MAX_W+3 -> clamped, exactly MAX_W pixels per row.
- During a 4x4 draw, pulse go with different x_in and colour -> ignored; output is identical to scenario 1. Assert resetn=0 at pixel 7 -> all outputs 0 at once, no done, then IDLE.
- x0=158, w=4, h=1, default widths: without RECT_CLIP_EN -> plots at x=158,159,160,161. With RECT_CLIP_EN -> plots at 158,159 only; the remaining two cycles have plot=0; done timing is unchanged.
- x0=254, w=4, without clipping -> x_out sequence 254,255,0,1 (wrap).

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: emits one (x, y, colour, plot) pixel per clock straight into the VGA write port.
// Latency: pixel (0,0) is shown the cycle after the go edge, then W*H pixel cycles, then a one-cycle done.
// Backpressure: none downstream; go is only honoured when busy=0, and all inputs are latched at that edge.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   go                       start request (sampled only while idle)
//   x_in, y_in               top-left origin
//   w_in, h_in               size in pixels, clamped to MAX_W / MAX_H
//   colour_in, outline       draw colour; 0 = filled, 1 = border only
//   busy, done               handshake: busy while drawing/finishing, done pulses one cycle at the end
//   x_out, y_out, colour_out, plot   registered pixel write to the VGA adapter
//
// Optional build macro RECT_CLIP_EN: suppress plot for pixels whose unwrapped coordinate falls off
// the SCREEN_W x SCREEN_H visible area. Without it coordinates simply wrap modulo 2^X_BITS / 2^Y_BITS.
module rect_fill_engine #(
    parameter int MAX_W       = 16,
    parameter int MAX_H       = 16,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         go,
    input  logic [X_BITS-1:0]            x_in,
    input  logic [Y_BITS-1:0]            y_in,
    input  logic [$clog2(MAX_W+1)-1:0]   w_in,
    input  logic [$clog2(MAX_H+1)-1:0]   h_in,
    input  logic [COLOUR_BITS-1:0]       colour_in,
    input  logic                         outline,
    output logic                         busy,
    output logic                         done,
    output logic [X_BITS-1:0]            x_out,
    output logic [Y_BITS-1:0]            y_out,
    output logic [COLOUR_BITS-1:0]       colour_out,
    output logic                         plot
);

    localparam int WW = $clog2(MAX_W + 1);
    localparam int HW = $clog2(MAX_H + 1);

    localparam logic [WW-1:0]     LP_MAX_W = WW'(MAX_W);
    localparam logic [HW-1:0]     LP_MAX_H = HW'(MAX_H);
    localparam logic [WW-1:0]     LP_W1    = WW'(1);
    localparam logic [HW-1:0]     LP_H1    = HW'(1);
    localparam logic [X_BITS:0]   LP_SCR_W = (X_BITS+1)'(SCREEN_W);
    localparam logic [Y_BITS:0]   LP_SCR_H = (Y_BITS+1)'(SCREEN_H);

`ifdef RECT_CLIP_EN
    localparam bit LP_CLIP = 1'b1;
`else
    localparam bit LP_CLIP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state, w_nxt_state;

    // Latched rectangle parameters
    logic [X_BITS-1:0]      r_x0;
    logic [Y_BITS-1:0]      r_y0;
    logic [WW-1:0]          r_w;
    logic [HW-1:0]          r_h;
    logic [COLOUR_BITS-1:0] r_colour;
    logic                   r_outline;

    // Offsets of the pixel currently on the outputs
    logic [WW-1:0]          r_xo, w_nxt_xo;
    logic [HW-1:0]          r_yo, w_nxt_yo;

    // Registered outputs
    logic                   r_busy, r_done, r_plot;
    logic [X_BITS-1:0]      r_x;
    logic [Y_BITS-1:0]      r_y;
    logic [COLOUR_BITS-1:0] r_colour_out;

    logic                   w_latch, w_emit, w_nxt_busy, w_nxt_done, w_nxt_plot;
    logic [WW-1:0]          w_cw;
    logic [HW-1:0]          w_ch;
    logic                   w_xend, w_last;

    // Pixel parameter sources: while idle the first pixel is built from the live inputs
    // (they are being latched on the same edge), afterwards from the latched copies.
    logic [X_BITS-1:0]      w_src_x0;
    logic [Y_BITS-1:0]      w_src_y0;
    logic [WW-1:0]          w_src_w;
    logic [HW-1:0]          w_src_h;
    logic [COLOUR_BITS-1:0] w_src_colour;
    logic                   w_src_outline;

    logic [X_BITS:0]        w_xsum;
    logic [Y_BITS:0]        w_ysum;
    logic                   w_border, w_on_screen;

    assign w_cw = (w_in > LP_MAX_W) ? LP_MAX_W : w_in;
    assign w_ch = (h_in > LP_MAX_H) ? LP_MAX_H : h_in;

    assign w_src_x0      = (r_state == S_IDLE) ? x_in      : r_x0;
    assign w_src_y0      = (r_state == S_IDLE) ? y_in      : r_y0;
    assign w_src_w       = (r_state == S_IDLE) ? w_cw      : r_w;
    assign w_src_h       = (r_state == S_IDLE) ? w_ch      : r_h;
    assign w_src_colour  = (r_state == S_IDLE) ? colour_in : r_colour;
    assign w_src_outline = (r_state == S_IDLE) ? outline   : r_outline;

    assign w_xend = (r_xo == r_w - LP_W1);
    assign w_last = w_xend && (r_yo == r_h - LP_H1);

    // One extra bit keeps the unwrapped coordinate for the on-screen test; the output takes the low bits.
    assign w_xsum = {1'b0, w_src_x0} + (X_BITS+1)'(w_nxt_xo);
    assign w_ysum = {1'b0, w_src_y0} + (Y_BITS+1)'(w_nxt_yo);

    assign w_border = !w_src_outline
                   || (w_nxt_xo == '0) || (w_nxt_xo == w_src_w - LP_W1)
                   || (w_nxt_yo == '0) || (w_nxt_yo == w_src_h - LP_H1);

    assign w_on_screen = !LP_CLIP || ((w_xsum < LP_SCR_W) && (w_ysum < LP_SCR_H));

    assign w_nxt_plot = w_emit && w_border && w_on_screen;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_xo    = r_xo;
        w_nxt_yo    = r_yo;
        w_latch     = 1'b0;
        w_emit      = 1'b0;
        w_nxt_busy  = 1'b0;
        w_nxt_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_latch    = 1'b1;
                    w_nxt_busy = 1'b1;
                    w_nxt_xo   = '0;
                    w_nxt_yo   = '0;
                    if ((w_cw == '0) || (w_ch == '0)) begin
                        // Degenerate rectangle: skip straight to the done cycle.
                        w_nxt_state = S_FINISH;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_state = S_DRAW;
                        w_emit      = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                w_nxt_busy = 1'b1;
                if (w_last) begin
                    w_nxt_state = S_FINISH;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_emit = 1'b1;
                    if (w_xend) begin
                        w_nxt_xo = '0;
                        w_nxt_yo = r_yo + LP_H1;
                    end else begin
                        w_nxt_xo = r_xo + LP_W1;
                    end
                end
            end
            S_FINISH: begin
                w_nxt_state = S_IDLE;
                w_nxt_xo    = '0;
                w_nxt_yo    = '0;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x0         <= '0;
            r_y0         <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_colour     <= '0;
            r_outline    <= 1'b0;
            r_xo         <= '0;
            r_yo         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour_out <= '0;
        end else begin
            r_xo   <= w_nxt_xo;
            r_yo   <= w_nxt_yo;
            r_busy <= w_nxt_busy;
            r_done <= w_nxt_done;
            r_plot <= w_nxt_plot;
            if (w_latch) begin
                r_x0      <= x_in;
                r_y0      <= y_in;
                r_w       <= w_cw;
                r_h       <= w_ch;
                r_colour  <= colour_in;
                r_outline <= outline;
            end
            if (w_emit) begin
                r_x          <= w_xsum[X_BITS-1:0];
                r_y          <= w_ysum[Y_BITS-1:0];
                r_colour_out <= w_src_colour;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign plot       = r_plot;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_colour_out;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Testbench for rect_fill_engine: scenario tasks compared against a raster-order reference model.
// Latency: expects pixel 0 the cycle after the go edge, W*H pixels, then a single done cycle.
// Backpressure: none; checks that go is ignored while busy and honoured at the first idle edge.
module tb_rect_fill_engine;

    localparam int MAX_W    = 16;
    localparam int MAX_H    = 16;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [4:0] w_in = '0;
    logic [4:0] h_in = '0;
    logic [2:0] colour_in = '0;
    logic       outline = 1'b0;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       p;
    } pix_t;

    rect_fill_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .x_in       (x_in),
        .y_in       (y_in),
        .w_in       (w_in),
        .h_in       (h_in),
        .colour_in  (colour_in),
        .outline    (outline),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    // Draw one rectangle and compare every cycle against the model. Called at a negedge with the
    // engine idle. inj >= 0 pulses go with scrambled inputs after pixel inj; hold leaves go high.
    task automatic run_rect(input string name, input int x0, input int y0, input int w, input int h,
                            input int col, input bit outl, input int inj, input bit hold);
        pix_t        q[$];
        pix_t        e;
        int          cw, ch, xs, ys;
        bit          on;
        logic [20:0] obs, exp_v;
        cw = (w > MAX_W) ? MAX_W : w;
        ch = (h > MAX_H) ? MAX_H : h;
        for (int yo = 0; yo < ch; yo++) begin
            for (int xo = 0; xo < cw; xo++) begin
                xs = x0 + xo;
                ys = y0 + yo;
                on = !outl || xo == 0 || xo == cw - 1 || yo == 0 || yo == ch - 1;
`ifdef RECT_CLIP_EN
                on = on && (xs < SCREEN_W) && (ys < SCREEN_H);
`endif
                e.x = 8'(xs % 256);
                e.y = 7'(ys % 128);
                e.p = on;
                q.push_back(e);
            end
        end
        x_in = 8'(x0); y_in = 7'(y0); w_in = 5'(w); h_in = 5'(h);
        colour_in = 3'(col); outline = outl; go = 1'b1;
        @(posedge clk); #1;
        if (!hold) go = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (inj >= 0 && i == inj + 1) go = 1'b0;
            obs   = {busy, done, plot, x_out, y_out, colour_out};
            exp_v = {1'b1, 1'b0, q[i].p, q[i].x, q[i].y, 3'(col)};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL %s pixel %0d: got busy/done/plot/x/y/col=%h want %h", name, i, obs, exp_v);
            end
            if (i == inj) begin
                go = 1'b1; x_in = x_in + 8'd37; colour_in = ~colour_in;
                outline = ~outline; w_in = 5'd1;
            end
        end
        go = hold;
        @(negedge clk);
        checks++;
        if ({busy, done, plot} !== 3'b110) begin
            failures++;
            $display("FAIL %s done_cycle: got busy/done/plot=%b want 110", name, {busy, done, plot});
        end
        @(negedge clk);
        checks++;
        if ({busy, done, plot} !== 3'b000) begin
            failures++;
            $display("FAIL %s after_done: got busy/done/plot=%b want 000", name, {busy, done, plot});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if ({busy, done, plot, x_out, y_out, colour_out} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", {busy, done, plot, x_out, y_out, colour_out});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, plot} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: got busy/done/plot=%b want 000", {busy, done, plot});
        end
    endtask

    task automatic test_fill();
        run_rect("fill_4x4", 10, 20, 4, 4, 5, 1'b0, -1, 1'b0);
    endtask

    task automatic test_outline();
        run_rect("outline_4x3", 0, 0, 4, 3, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_zero_size();
        run_rect("zero_w", 30, 40, 0, 5, 7, 1'b0, -1, 1'b0);
        run_rect("zero_h", 30, 40, 6, 0, 7, 1'b1, -1, 1'b0);
    endtask

    task automatic test_clamp();
        run_rect("clamp_w", 3, 9, MAX_W + 3, 2, 6, 1'b0, -1, 1'b0);
        run_rect("clamp_h_outline", 3, 9, 2, MAX_H + 5, 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_ignore_go();
        run_rect("go_while_busy", 10, 20, 4, 4, 5, 1'b0, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [20:0] obs;
        x_in = 8'd10; y_in = 7'd20; w_in = 5'd4; h_in = 5'd4; colour_in = 3'd5; outline = 1'b0;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (8) @(negedge clk);
        obs = {busy, done, plot, x_out, y_out, colour_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'd13, 7'd21, 3'd5}) begin
            failures++;
            $display("FAIL mid_pixel7: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'd13, 7'd21, 3'd5});
        end
        resetn = 1'b0;
        #1;
        obs = {busy, done, plot, x_out, y_out, colour_out};
        checks++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL mid_reset_now: got %h want 0", obs);
        end
        @(negedge clk);
        obs = {busy, done, plot, x_out, y_out, colour_out};
        checks++;
        if (obs !== 21'd0) begin
            failures++;
            $display("FAIL mid_reset_hold: got %h want 0", obs);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, plot} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_idle: got busy/done/plot=%b want 000", {busy, done, plot});
        end
    endtask

    task automatic test_screen_edge();
        run_rect("screen_edge", 158, 5, 4, 1, 3, 1'b0, -1, 1'b0);
        run_rect("screen_bottom", 20, 118, 2, 4, 4, 1'b0, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_rect("wrap_x", 254, 60, 4, 1, 6, 1'b0, -1, 1'b0);
        run_rect("wrap_xy_outline", 253, 126, 5, 4, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_rect("b2b_first", 40, 50, 3, 2, 1, 1'b0, -1, 1'b1);
        run_rect("b2b_second", 70, 10, 2, 3, 4, 1'b1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_rect("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, MAX_W + 3)), int'($urandom_range(0, MAX_H + 3)),
                     int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     (n % 4 == 0) ? 0 : -1, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_outline();
        test_zero_size();
        test_clamp();
        test_ignore_go();
        test_reset_mid();
        test_screen_edge();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
